// File: rtl/ccu_snoop_responder_pkg.sv
// Shared types for the snoop responder: AC/CR/CD bundles, CR response
// layout, state-update opcode and the snoop decode table.
package ccu_snoop_responder_pkg;

  localparam int unsigned SNOOP_ADDR_W = 64;
  localparam int unsigned SNOOP_DATA_W = 64;

  // ACE AC snoop opcodes handled by this responder
  localparam logic [3:0] SNOOP_READ_ONCE        = 4'h0;
  localparam logic [3:0] SNOOP_READ_SHARED      = 4'h1;
  localparam logic [3:0] SNOOP_READ_CLEAN       = 4'h2;
  localparam logic [3:0] SNOOP_READ_NSD         = 4'h3;
  localparam logic [3:0] SNOOP_CLEAN_SHARED     = 4'h8;
  localparam logic [3:0] SNOOP_CLEAN_INVALID    = 4'h9;
  localparam logic [3:0] SNOOP_MAKE_INVALID     = 4'hD;

  typedef enum logic {
    UPD_INVALIDATE        = 1'b0,
    UPD_MAKE_SHARED_CLEAN = 1'b1
  } snoop_upd_op_e;

  // Bit order matches ACE CRRESP[4:0]
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } cr_resp_t;

  typedef struct packed {
    logic [SNOOP_DATA_W-1:0] data;
    logic                    last;
  } cd_t;

  typedef struct packed {
    logic                    ac_valid;
    logic [SNOOP_ADDR_W-1:0] ac_addr;
    logic [3:0]              ac_snoop;
    logic                    cr_ready;
    logic                    cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_resp_t cr_resp;
    logic     cd_valid;
    cd_t      cd;
  } snoop_resp_t;

  typedef struct packed {
    cr_resp_t      resp;
    logic          upd;
    snoop_upd_op_e op;
  } snoop_decision_t;

  function automatic logic snoop_supported(input logic [3:0] op);
    return (op == SNOOP_READ_ONCE)     || (op == SNOOP_READ_SHARED)   ||
           (op == SNOOP_READ_CLEAN)    || (op == SNOOP_READ_NSD)      ||
           (op == SNOOP_CLEAN_SHARED)  || (op == SNOOP_CLEAN_INVALID) ||
           (op == SNOOP_MAKE_INVALID);
  endfunction

  // Response and required state change for a supported opcode
  function automatic snoop_decision_t snoop_decode(input logic [3:0] op,
                                                   input logic hit,
                                                   input logic dirty,
                                                   input logic shared);
    snoop_decision_t d;
    d = '0;
    if (hit) begin
      d.resp.was_unique = !shared;
      case (op)
        SNOOP_READ_ONCE: begin
          d.resp.data_transfer = 1'b1;
          d.resp.is_shared     = 1'b1;
        end
        SNOOP_READ_SHARED, SNOOP_READ_CLEAN, SNOOP_READ_NSD: begin
          d.resp.data_transfer = 1'b1;
          d.resp.is_shared     = 1'b1;
          d.resp.pass_dirty    = dirty;
          d.upd                = 1'b1;
          d.op                 = UPD_MAKE_SHARED_CLEAN;
        end
        SNOOP_CLEAN_SHARED: begin
          d.resp.data_transfer = dirty;
          d.resp.is_shared     = 1'b1;
          d.resp.pass_dirty    = dirty;
          d.upd                = dirty;
          d.op                 = UPD_MAKE_SHARED_CLEAN;
        end
        SNOOP_CLEAN_INVALID: begin
          d.resp.data_transfer = dirty;
          d.resp.pass_dirty    = dirty;
          d.upd                = 1'b1;
          d.op                 = UPD_INVALIDATE;
        end
        SNOOP_MAKE_INVALID: begin
          d.upd = 1'b1;
          d.op  = UPD_INVALIDATE;
        end
        default: d = '0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/ccu_snoop_responder_cd_serializer.sv
// Holds the looked-up cache line and streams it onto CD one word per
// handshake, least-significant word first.
module ccu_snoop_responder_cd_serializer
  import ccu_snoop_responder_pkg::*;
#(
  parameter int unsigned DcacheLineWidth = 512,
  parameter int unsigned AxiDataWidth    = SNOOP_DATA_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_i,
  input  logic [DcacheLineWidth-1:0] line_i,
  input  logic                       start_i,
  input  logic                       cd_ready_i,
  output logic                       cd_valid_o,
  output logic [AxiDataWidth-1:0]    cd_data_o,
  output logic                       cd_last_o,
  output logic                       done_o
);

  localparam int unsigned Words = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned CntW  = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Words - 1);

  logic [Words-1:0][AxiDataWidth-1:0] line_q;
  logic [CntW-1:0]                    cnt_q;
  logic                               valid_q;
  logic                               last;

  assign last       = (cnt_q == LastIdx);
  assign cd_valid_o = valid_q;
  assign cd_data_o  = line_q[cnt_q];
  assign cd_last_o  = last;
  assign done_o     = valid_q && cd_ready_i && last;

  // Line capture, burst start and beat advance on every CD handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i) line_q <= line_i;
      if (start_i) begin
        valid_q <= 1'b1;
        cnt_q   <= '0;
      end else if (valid_q && cd_ready_i) begin
        if (last) begin
          valid_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccu_snoop_responder.sv
// Snoop responder: accepts one AC snoop, looks the line up in the private
// dcache, applies the coherence update, answers on CR and streams data on CD.
module ccu_snoop_responder
  import ccu_snoop_responder_pkg::*;
#(
  parameter int unsigned DcacheLineWidth = 512,
  parameter int unsigned AxiDataWidth    = SNOOP_DATA_W,
  parameter int unsigned AddrWidth       = SNOOP_ADDR_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  snoop_req_t                 snoop_req_i,
  output snoop_resp_t                snoop_resp_o,
  output logic                       lookup_req_o,
  output logic [AddrWidth-1:0]       lookup_addr_o,
  input  logic                       lookup_gnt_i,
  input  logic                       lookup_valid_i,
  input  logic                       lookup_hit_i,
  input  logic                       lookup_dirty_i,
  input  logic                       lookup_shared_i,
  input  logic [DcacheLineWidth-1:0] lookup_data_i,
  output logic                       upd_valid_o,
  output snoop_upd_op_e              upd_op_o,
  input  logic                       upd_ready_i
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOOKUP      = 3'd1;
  localparam logic [2:0] S_WAIT_LOOKUP = 3'd2;
  localparam logic [2:0] S_UPDATE      = 3'd3;
  localparam logic [2:0] S_SEND_CR     = 3'd4;
  localparam logic [2:0] S_SEND_CD     = 3'd5;

  localparam int unsigned LineBytes = DcacheLineWidth / 8;
  localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(LineBytes - 1);

  logic [2:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           snoop_q, snoop_d;
  cr_resp_t             resp_q, resp_d;
  snoop_upd_op_e        upd_op_q, upd_op_d;
  snoop_decision_t      dec;

  logic                    ser_load, ser_start, ser_valid, ser_last, ser_done;
  logic [AxiDataWidth-1:0] ser_data;

  assign dec       = snoop_decode(snoop_q, lookup_hit_i, lookup_dirty_i, lookup_shared_i);
  assign ser_load  = (state_q == S_WAIT_LOOKUP) && lookup_valid_i;
  assign ser_start = (state_q == S_SEND_CR) && snoop_req_i.cr_ready && resp_q.data_transfer;

  // Next-state and latched snoop context
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    snoop_d  = snoop_q;
    resp_d   = resp_q;
    upd_op_d = upd_op_q;
    case (state_q)
      S_IDLE: begin
        if (snoop_req_i.ac_valid) begin
          addr_d  = snoop_req_i.ac_addr[AddrWidth-1:0];
          snoop_d = snoop_req_i.ac_snoop;
          if (snoop_supported(snoop_req_i.ac_snoop)) begin
            state_d = S_LOOKUP;
          end else begin
            resp_d       = '0;
            resp_d.error = 1'b1;
            state_d      = S_SEND_CR;
          end
        end
      end
      S_LOOKUP: if (lookup_gnt_i) state_d = S_WAIT_LOOKUP;
      S_WAIT_LOOKUP: begin
        if (lookup_valid_i) begin
          resp_d   = dec.resp;
          upd_op_d = dec.op;
          state_d  = dec.upd ? S_UPDATE : S_SEND_CR;
        end
      end
      S_UPDATE: if (upd_ready_i) state_d = S_SEND_CR;
      S_SEND_CR: begin
        if (snoop_req_i.cr_ready) state_d = resp_q.data_transfer ? S_SEND_CD : S_IDLE;
      end
      S_SEND_CD: if (ser_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and context registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      snoop_q  <= '0;
      resp_q   <= '0;
      upd_op_q <= UPD_INVALIDATE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      snoop_q  <= snoop_d;
      resp_q   <= resp_d;
      upd_op_q <= upd_op_d;
    end
  end

  ccu_snoop_responder_cd_serializer #(
    .DcacheLineWidth (DcacheLineWidth),
    .AxiDataWidth    (AxiDataWidth)
  ) i_cd_ser (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ser_load),
    .line_i     (lookup_data_i),
    .start_i    (ser_start),
    .cd_ready_i (snoop_req_i.cd_ready),
    .cd_valid_o (ser_valid),
    .cd_data_o  (ser_data),
    .cd_last_o  (ser_last),
    .done_o     (ser_done)
  );

  // Outputs decoded from state; everything forced low while reset is held
  always_comb begin
    snoop_resp_o  = '0;
    lookup_req_o  = 1'b0;
    lookup_addr_o = '0;
    upd_valid_o   = 1'b0;
    upd_op_o      = UPD_INVALIDATE;
    if (!rst_i) begin
      snoop_resp_o.ac_ready = (state_q == S_IDLE);
      snoop_resp_o.cr_valid = (state_q == S_SEND_CR);
      if (state_q == S_SEND_CR) snoop_resp_o.cr_resp = resp_q;
      snoop_resp_o.cd_valid = ser_valid;
      if (ser_valid) begin
        snoop_resp_o.cd.data = ser_data;
        snoop_resp_o.cd.last = ser_last;
      end
      lookup_req_o  = (state_q == S_LOOKUP);
      lookup_addr_o = addr_q & ~OffMask;
      upd_valid_o   = (state_q == S_UPDATE);
      upd_op_o      = upd_op_q;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_responder.sv
// Directed, table-driven bench for ccu_snoop_responder (512-bit line, 64-bit CD).
module tb_ccu_snoop_responder;
  import ccu_snoop_responder_pkg::*;

  localparam int LW = 512;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int NW = LW / DW;

  logic          clk = 1'b0;
  logic          rst_i;
  snoop_req_t    req;
  snoop_resp_t   resp;
  logic          lookup_req;
  logic [AW-1:0] lookup_addr;
  logic          gnt, lvalid, lhit, ldirty, lshared;
  logic [LW-1:0] ldata;
  logic          upd_valid;
  snoop_upd_op_e upd_op;
  logic          upd_ready;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ccu_snoop_responder #(
    .DcacheLineWidth (LW),
    .AxiDataWidth    (DW),
    .AddrWidth       (AW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .snoop_req_i     (req),
    .snoop_resp_o    (resp),
    .lookup_req_o    (lookup_req),
    .lookup_addr_o   (lookup_addr),
    .lookup_gnt_i    (gnt),
    .lookup_valid_i  (lvalid),
    .lookup_hit_i    (lhit),
    .lookup_dirty_i  (ldirty),
    .lookup_shared_i (lshared),
    .lookup_data_i   (ldata),
    .upd_valid_o     (upd_valid),
    .upd_op_o        (upd_op),
    .upd_ready_i     (upd_ready)
  );

  typedef struct {
    logic [3:0] op;
    logic       hit;
    logic       dirty;
    logic       shared;
    logic [4:0] resp;    // {wasUnique, isShared, passDirty, error, dataTransfer}
    logic       upd;
    logic       uop;     // 0 INVALIDATE, 1 MAKE_SHARED_CLEAN
    int         stall_beat;
    int         stall_cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One complete snoop; abort_beat >= 0 returns while that CD beat is presented
  task automatic do_snoop(input vec_t v, input int idx, input int abort_beat);
    logic [63:0] addr;
    logic [63:0] w [NW];
    logic        sup, saw_upd;
    int          k, held;
    addr = 64'h0000_1234_5678_0000 + 64'(idx) * 64 + 64'(idx % 8) * 8 + 64'd3;
    for (int i = 0; i < NW; i++) begin
      w[i] = 64'hC0DE_0000_0000_0000 | (64'(idx) << 16) | 64'(i);
      ldata[i*DW +: DW] = w[i];
    end
    sup = !v.resp[1];
    @(negedge clk);
    chk("ac_ready_idle", 64'(resp.ac_ready), 64'd1);
    req.ac_valid = 1'b1; req.ac_addr = addr; req.ac_snoop = v.op;
    @(negedge clk);
    req.ac_valid = 1'b0;
    chk("ac_ready_busy", 64'(resp.ac_ready), 64'd0);
    chk("lookup_req", 64'(lookup_req), 64'(sup));
    if (sup) begin
      chk("lookup_addr", lookup_addr, addr & ~64'h3F);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      lvalid = 1'b1; lhit = v.hit; ldirty = v.dirty; lshared = v.shared;
      @(negedge clk);
      lvalid = 1'b0;
    end
    saw_upd = 1'b0; held = 0; k = 0;
    while (!resp.cr_valid && k < 20) begin
      upd_ready = 1'b0;
      if (upd_valid) begin
        saw_upd = 1'b1;
        chk("upd_op", 64'(upd_op), 64'(v.uop));
        if (held > 0) upd_ready = 1'b1;
        held++;
      end
      @(negedge clk);
      k++;
    end
    upd_ready = 1'b0;
    chk("cr_valid", 64'(resp.cr_valid), 64'd1);
    chk("update_seen", 64'(saw_upd), 64'(v.upd));
    chk("cr_latency", 64'(k), v.upd ? 64'd2 : 64'd0);
    chk("cr_resp", 64'(resp.cr_resp), 64'(v.resp));
    @(negedge clk);
    chk("cr_hold", 64'({resp.cr_valid, resp.cr_resp}), 64'({1'b1, v.resp}));
    req.cr_ready = 1'b1;
    @(negedge clk);
    req.cr_ready = 1'b0;
    if (v.resp[0]) begin
      for (int b = 0; b < NW; b++) begin
        chk("cd_valid", 64'(resp.cd_valid), 64'd1);
        chk("cd_data", resp.cd.data, w[b]);
        chk("cd_last", 64'(resp.cd.last), 64'(b == NW - 1));
        if (b == abort_beat) return;
        if (b == v.stall_beat) begin
          repeat (v.stall_cyc) begin
            @(negedge clk);
            chk("cd_hold", {resp.cd.data[62:0], resp.cd_valid}, {w[b][62:0], 1'b1});
          end
        end
        req.cd_ready = 1'b1;
        @(negedge clk);
        req.cd_ready = 1'b0;
      end
    end
    chk("cd_quiet", 64'(resp.cd_valid), 64'd0);
    chk("back_idle", 64'(resp.ac_ready), 64'd1);
  endtask

  initial begin
    vecs[0]  = '{4'h1, 1'b1, 1'b1, 1'b0, 5'b11101, 1'b1, 1'b1,  2, 3}; // READ_SHARED dirty
    vecs[1]  = '{4'h9, 1'b1, 1'b0, 1'b0, 5'b10000, 1'b1, 1'b0, -1, 0}; // CLEAN_INVALID clean
    vecs[2]  = '{4'hD, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, -1, 0}; // MAKE_INVALID miss
    vecs[3]  = '{4'hF, 1'b0, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b0, -1, 0}; // unsupported
    vecs[4]  = '{4'h0, 1'b1, 1'b1, 1'b1, 5'b01001, 1'b0, 1'b0, -1, 0}; // READ_ONCE
    vecs[5]  = '{4'h8, 1'b1, 1'b1, 1'b1, 5'b01101, 1'b1, 1'b1,  5, 1}; // CLEAN_SHARED dirty
    vecs[6]  = '{4'h8, 1'b1, 1'b0, 1'b0, 5'b11000, 1'b0, 1'b0, -1, 0}; // CLEAN_SHARED clean
    vecs[7]  = '{4'h3, 1'b1, 1'b0, 1'b1, 5'b01001, 1'b1, 1'b1, -1, 0}; // READ_NSD clean
    vecs[8]  = '{4'h7, 1'b1, 1'b1, 1'b0, 5'b00010, 1'b0, 1'b0, -1, 0}; // READ_UNIQUE unsupported
    vecs[9]  = '{4'h9, 1'b1, 1'b1, 1'b1, 5'b00101, 1'b1, 1'b0,  0, 2}; // CLEAN_INVALID dirty
    vecs[10] = '{4'hD, 1'b1, 1'b1, 1'b0, 5'b10000, 1'b1, 1'b0, -1, 0}; // MAKE_INVALID hit
    vecs[11] = '{4'h2, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, -1, 0}; // READ_CLEAN miss

    rst_i = 1'b1; req = '0; gnt = 1'b0; lvalid = 1'b0; lhit = 1'b0;
    ldirty = 1'b0; lshared = 1'b0; ldata = '0; upd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ac_ready", 64'(resp.ac_ready), 64'd0);
    chk("rst_resp_zero", 64'(resp != '0), 64'd0);
    chk("rst_lookup_req", 64'(lookup_req), 64'd0);
    chk("rst_upd_valid", 64'(upd_valid), 64'd0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ac_ready", 64'(resp.ac_ready), 64'd1);

    for (int i = 0; i < 12; i++) do_snoop(vecs[i], i, -1);

    // Reset while beat 4 of a burst is on CD
    do_snoop(vecs[0], 20, 4);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_resp_zero", 64'(resp != '0), 64'd0);
    chk("midrst_lookup", 64'({lookup_req, upd_valid, 1'(upd_op)}), 64'd0);
    chk("midrst_addr", lookup_addr, 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("midrst_ac_ready", 64'(resp.ac_ready), 64'd1);
    chk("midrst_cd_quiet", 64'(resp.cd_valid), 64'd0);
    do_snoop(vecs[0], 21, -1);
    do_snoop(vecs[4], 22, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
